// File: rtl/pipe_sequencer_pkg.sv
// Shared types and field layout for the table-driven pattern sequencer.
// Table words are {duration, pattern}; a zero duration ends the table.
package pipe_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    RUN
  } state_e;

  localparam int DUR_MSB = 31;
  localparam int DUR_LSB = 16;
  localparam int PAT_MSB = 15;
  localparam int PAT_LSB = 0;

  localparam logic [15:0] END_MARKER = 16'h0000;

endpackage

// File: rtl/pipe_sequencer_if.sv
// Table RAM read bus: address out, word back one clock later.
// The sequencer is the master; the table RAM is the slave.
interface pipe_sequencer_if #(
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;

  modport master (
    output addr,
    input  data
  );

  modport slave (
    input  addr,
    output data
  );

endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter timing how long each step stays in RUN.
// Load wins over enable; zero_o is a plain decode of the count.
module seq_timer #(
  parameter int DUR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DUR_W-1:0] val_i,
  output logic [DUR_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [DUR_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_sequencer.sv
// Plays a {duration, pattern} table from RAM, optionally looping,
// holding each pattern for duration+2 clocks.
module pipe_sequencer
  import pipe_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DUR_W  = 16
) (
  input  logic              clk_i,
  input  logic              restart_i,
  input  logic [ADDR_W-1:0] saddr_i,
  input  logic [7:0]        reps_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [31:0]       data32_i,
  output logic [15:0]       pattern_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       steps_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       pat_q;
  logic [15:0]       steps_q;
  logic [7:0]        rep_q;
  logic              busy_q;
  logic              done_q;

  logic [DUR_W-1:0]  dur;
  logic [DUR_W-1:0]  dur_d;
  logic [DUR_W-1:0]  dur_cnt;
  logic              dur_zero;
  logic              is_end;
  logic              abort;
  logic              tmr_load;
  logic              tmr_en;

  assign dur    = data32_i[DUR_MSB:DUR_LSB];
  assign dur_d  = dur - 1'b1;
  assign is_end = (dur == DUR_W'(END_MARKER));
  assign abort  = stop_i && (state_q != IDLE);

  assign tmr_load = (state_q == DECODE) && !abort && !is_end;
  assign tmr_en   = (state_q == RUN) && !abort && !dur_zero;

  seq_timer #(
    .DUR_W (DUR_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (restart_i),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .val_i  (dur_d),
    .cnt_o  (dur_cnt),
    .zero_o (dur_zero)
  );

  always_ff @(posedge clk_i) begin
    done_q <= 1'b0;
    if (restart_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pat_q   <= '0;
      steps_q <= '0;
      rep_q   <= '0;
      busy_q  <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      pat_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q  <= saddr_i;
            rep_q   <= reps_i;
            steps_q <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: state_q <= DECODE;
        DECODE: begin
          if (!is_end) begin
            pat_q   <= data32_i[PAT_MSB:PAT_LSB];
            addr_q  <= addr_q + 1'b1;
            steps_q <= steps_q + 1'b1;
            state_q <= RUN;
          end else if (rep_q != '0) begin
            rep_q   <= rep_q - 1'b1;
            addr_q  <= saddr_i;
            state_q <= FETCH;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (dur_zero) state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_o    = addr_q;
  assign pattern_o = pat_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign steps_o   = steps_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboarded directed test: scenarios queue expected pattern/done/abort
// events with cycle offsets; a monitor compares what the DUT shows.
module tb_pipe_sequencer;

  localparam int K_PAT  = 0;
  localparam int K_DONE = 1;
  localparam int K_ABRT = 2;

  typedef struct {
    int kind;
    int val;
    int off;
  } ev_t;

  logic        clk = 1'b0;
  logic        restart;
  logic [15:0] saddr;
  logic [7:0]  reps;
  logic        start;
  logic        stop;
  logic [15:0] pattern_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] steps_o;

  pipe_sequencer_if #(.ADDR_W(16)) bus ();

  logic [31:0] ram [0:65535];

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  t0    = 0;
  bit  mon_en = 1'b0;

  pipe_sequencer #(
    .ADDR_W (16),
    .DUR_W  (16)
  ) dut (
    .clk_i     (clk),
    .restart_i (restart),
    .saddr_i   (saddr),
    .reps_i    (reps),
    .start_i   (start),
    .stop_i    (stop),
    .addr_o    (bus.addr),
    .data32_i  (bus.data),
    .pattern_o (pattern_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .steps_o   (steps_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.data <= ram[bus.addr];

  task automatic expect_ev(input int k, input int v, input int o);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.off  = o;
    q.push_back(e);
  endtask

  task automatic got_ev(input int k, input int v);
    ev_t e;
    int  o;
    o = cyc - t0;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_ev: kind=%0d val=%0h off=%0d", k, v, o);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val != v || e.off != o) begin
        bad++;
        $display("FAIL ev: got kind=%0d val=%0h off=%0d want kind=%0d val=%0h off=%0d",
                 k, v, o, e.kind, e.val, e.off);
      end
    end
  endtask

  initial begin : monitor
    logic [15:0] prev_pat;
    logic        prev_busy;
    prev_pat  = '0;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (pattern_o !== prev_pat) got_ev(K_PAT, int'(pattern_o));
        if (done_o) got_ev(K_DONE, int'(steps_o));
        else if (prev_busy && !busy_o) got_ev(K_ABRT, int'(pattern_o));
      end
      prev_pat  = pattern_o;
      prev_busy = busy_o;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic go(input logic [15:0] sa, input logic [7:0] rp,
                    input logic with_stop);
    @(negedge clk);
    saddr = sa;
    reps  = rp;
    start = 1'b1;
    stop  = with_stop;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic before_edge(input int k);
    while (cyc < t0 + k - 1) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy_o) begin
      bad++;
      $display("FAIL %s_timeout: busy=%0b want=0", nm, busy_o);
    end
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: left=%0d want=0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic exp_basic();
    expect_ev(K_PAT, 'hA5, 2);
    expect_ev(K_PAT, 'h5A, 7);
    expect_ev(K_DONE, 2, 10);
  endtask

  initial begin
    restart = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    saddr   = '0;
    reps    = '0;
    ram[16'h0010] = 32'h0003_00A5;
    ram[16'h0011] = 32'h0001_005A;
    ram[16'h0012] = 32'h0000_0000;
    ram[16'hFFFF] = 32'h0002_0001;
    ram[16'h0000] = 32'h0000_0000;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pat", 32'(pattern_o), 32'd0);
    chk("rst_steps", 32'(steps_o), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    restart = 1'b0;
    mon_en  = 1'b1;

    exp_basic();
    go(16'h0010, 8'd0, 1'b0);
    wait_idle("basic");

    for (int p = 0; p < 3; p++) begin
      expect_ev(K_PAT, 'hA5, 2 + 10 * p);
      expect_ev(K_PAT, 'h5A, 7 + 10 * p);
    end
    expect_ev(K_DONE, 6, 30);
    go(16'h0010, 8'd2, 1'b0);
    wait_idle("reps");

    expect_ev(K_PAT, 'hA5, 2);
    expect_ev(K_PAT, 'h5A, 7);
    expect_ev(K_PAT, 0, 8);
    expect_ev(K_ABRT, 0, 8);
    go(16'h0010, 8'd0, 1'b0);
    before_edge(8);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", 32'(busy_o), 32'd0);
    chk("stop_pat", 32'(pattern_o), 32'd0);
    wait_idle("stop");

    expect_ev(K_PAT, 'h0001, 2);
    expect_ev(K_DONE, 1, 6);
    go(16'hFFFF, 8'd0, 1'b0);
    wait_idle("wrap");
    chk("wrap_addr", 32'(bus.addr), 32'd0);

    exp_basic();
    go(16'h0010, 8'd0, 1'b0);
    before_edge(4);
    start = 1'b1;
    saddr = 16'h0012;
    reps  = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");

    expect_ev(K_PAT, 'hA5, 2);
    expect_ev(K_PAT, 0, 4);
    expect_ev(K_ABRT, 0, 4);
    go(16'h0010, 8'd0, 1'b0);
    before_edge(4);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rr_busy", 32'(busy_o), 32'd0);
    chk("rr_pat", 32'(pattern_o), 32'd0);
    chk("rr_addr", 32'(bus.addr), 32'd0);
    chk("rr_steps", 32'(steps_o), 32'd0);
    chk("rr_done", 32'(done_o), 32'd0);
    wait_idle("restart");
    exp_basic();
    go(16'h0010, 8'd0, 1'b0);
    wait_idle("after_rr");

    exp_basic();
    go(16'h0010, 8'd0, 1'b1);
    wait_idle("start_stop");

    expect_ev(K_DONE, 0, 2);
    go(16'h0012, 8'd0, 1'b0);
    wait_idle("empty");
    chk("empty_steps", 32'(steps_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter: ADDR_W, 16, RAM word-address width.
REQ-002 SHALL have parameter: DUR_W, 16, step duration field width, occupying data32_i[31:16].
REQ-003 SHALL have port: clk_i  input  1  single clock; all logic on posedge; synchronous, active-high reset.
REQ-004 SHALL have port: restart_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: saddr_i  input  16  table start word address, sampled on start and on each loop.
REQ-006 SHALL have port: reps_i  input  8  extra passes after the first, sampled on start (0 = play once).
REQ-007 SHALL have port: start_i  input  1  start pulse, honoured only in IDLE.
REQ-008 SHALL have port: stop_i  input  1  abort request.
REQ-009 SHALL have port: addr_o  output  16  RAM read address; RAM data is valid on data32_i one clock after addr_o changes.
REQ-010 SHALL have port: data32_i  input  32  RAM read data, {duration[15:0], pattern[15:0]}.
REQ-011 SHALL have port: pattern_o  output  16  registered output pattern.
REQ-012 SHALL have port: busy_o  output  1  high in every state except IDLE.
REQ-013 SHALL have port: done_o  output  1  one-cycle pulse on normal completion.
REQ-014 SHALL have port: steps_o  output  16  steps executed since last start, wraps at 16'hFFFF.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, RUN.
REQ-016 IDLE: on start_i, SHALL load addr_o<=saddr_i, rep_cnt<=reps_i and steps_o<=0, then go to FETCH; otherwise SHALL stay in IDLE.
REQ-017 FETCH: SHALL wait exactly one cycle (RAM latency), then go to DECODE.
REQ-018 DECODE: if data32_i[31:16]==0 (end marker), SHALL not change pattern_o and SHALL go to the end-of-table handling in REQ-021.
REQ-019 DECODE: otherwise SHALL load pattern_o<=data32_i[15:0], dur_cnt<=duration-1, addr_o<=addr_o+1 and steps_o<=steps_o+1, then go to RUN.
REQ-020 RUN: SHALL decrement dur_cnt each cycle; at dur_cnt==0 SHALL go to FETCH; each step SHALL hold its pattern for exactly duration+2 clocks (RUN + FETCH + DECODE).
REQ-021 End of table: if rep_cnt!=0, SHALL set rep_cnt<=rep_cnt-1 and addr_o<=saddr_i, then go to FETCH; otherwise SHALL assert done_o for one cycle and go to IDLE with pattern_o held.
REQ-022 addr_o SHALL wrap from 16'hFFFF to 16'h0000 with no error.
REQ-023 stop_i in any non-IDLE state SHALL force IDLE next cycle with pattern_o<=0 and no done_o; stop_i in IDLE SHALL have no effect.
REQ-024 stop_i SHALL take priority over all state transitions; restart_i SHALL take priority over stop_i and start_i.
REQ-025 start_i while busy_o=1 SHALL be ignored.
REQ-026 start_i and stop_i together in IDLE SHALL start the sequence (stop_i is ignored in IDLE).
REQ-027 A table whose first word is an end marker with reps_i=0 SHALL produce done_o exactly 2 cycles after start_i, with steps_o=0.

Reset
REQ-028 restart_i=1 SHALL set state=IDLE, addr_o=0, pattern_o=0, busy_o=0, done_o=0, steps_o=0, dur_cnt=0 and rep_cnt=0 on the next edge.
REQ-029 restart_i asserted mid-RUN SHALL abort immediately with no done_o.

Structure
REQ-030 A shared package SHALL hold: the state encoding, field constants DUR_MSB=31, DUR_LSB=16, PAT_MSB=15, PAT_LSB=0, and END_MARKER=16'h0000.
REQ-031 There SHALL be one sub-module, seq_timer: a loadable DUR_W down-counter with load, enable and zero flag, used for dur_cnt.

Verification
REQ-032 Bench SHALL cover: table @0x0010 = {0x0003_00A5, 0x0001_005A, 0x0000_0000}, reps_i=0, start -> pattern 0x00A5 for 5 clocks, then 0x005A for 3 clocks, done_o 2 cycles later, steps_o=2.
REQ-033 Bench SHALL cover: same table with reps_i=2 -> pattern sequence repeats 3 times, done_o once, steps_o=6.
REQ-034 Bench SHALL cover: stop_i during the second step's RUN -> busy_o=0 and pattern_o=0 next cycle, no done_o.
REQ-035 Bench SHALL cover: saddr_i=0xFFFF, words @0xFFFF=0x0002_0001 and @0x0000=0 -> addr_o wraps to 0x0000, done_o asserted, steps_o=1.
REQ-036 Bench SHALL cover: start_i pulsed during RUN -> ignored, and the in-flight sequence timing is unchanged.
REQ-037 Bench SHALL cover: restart_i mid-RUN -> all outputs 0 next cycle, and a subsequent start runs normally.
